regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RISC-V core, replacing the single-write, two-read file.
- Two write ports, NRD combinational read ports, and x0 hardwired to zero.
- Sequential init sweep after reset, with an init_done handshake.
- Per-register scoreboard (busy bits) used by the issue stage for RAW hazard detection.
- Sits between decode/issue (reads, scoreboard set) and writeback (two retire lanes).

---
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_mp.sv | 106 ++++++++++
 tb/tb_regfile_mp.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: the two retire-lane write ports, the read ports, the scoreboard set port and init status.
// The master side is decode/issue/writeback and the slave side is the register file.
`timescale 1ns/1ps
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic                wr0_en;
    logic [AW-1:0]       wr0_addr;
    logic [XLEN-1:0]     wr0_data;
    logic                wr1_en;
    logic [AW-1:0]       wr1_addr;
    logic [XLEN-1:0]     wr1_data;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                sb_set_en;
    logic [AW-1:0]       sb_set_addr;
    logic                init_done;

    modport master (
        output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
        output rd_addr, sb_set_en, sb_set_addr,
        input  rd_data, rd_busy, init_done
    );

    modport slave (
        input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
        input  rd_addr, sb_set_en, sb_set_addr,
        output rd_data, rd_busy, init_done
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a post-reset zeroing sweep and per-register RAW scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
`timescale 1ns/1ps
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic {INIT, READY} state_t;

    state_t            state;
    state_t            stateNext;
    logic [AW-1:0]     idx;
    logic [XLEN-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  setMask;
    logic [DEPTH-1:0]  clrMask;
    logic              ready;
    logic              wr0Live;
    logic              wr1Live;
    logic              sbLive;

    assign ready   = (state == READY);
    assign wr0Live = ready & bus.wr0_en & (bus.wr0_addr != '0);
    assign wr1Live = ready & bus.wr1_en & (bus.wr1_addr != '0);
    assign sbLive  = ready & bus.sb_set_en & (bus.sb_set_addr != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            idx   <= '0;
        end else begin
            state <= stateNext;
            if (state == INIT) idx <= idx + AW'(1);
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves stateNext unassigned and infers a latch.
        stateNext = state;
        case (state)
            INIT:    if (idx == AW'(DEPTH - 1)) stateNext = READY;
            default: stateNext = state;
        endcase
    end

    assign bus.init_done = ready;

    // NOTE: storage has no reset branch on purpose; rst leaves contents alone and the INIT sweep zeroes them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                regs[idx] <= '0;
            end else begin
                if (wr0Live) regs[bus.wr0_addr] <= bus.wr0_data;
                if (wr1Live) regs[bus.wr1_addr] <= bus.wr1_data;
            end
        end
    end

    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (sbLive)  setMask[bus.sb_set_addr] = 1'b1;
        if (wr0Live) clrMask[bus.wr0_addr]    = 1'b1;
        if (wr1Live) clrMask[bus.wr1_addr]    = 1'b1;
    end

    // A newly issued producer supersedes the retiring one, so set overrides clear.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= ((busy & ~clrMask) | setMask) & ~DEPTH'(1);
    end

    wire [NRD*XLEN-1:0] rdDataW;
    wire [NRD-1:0]      rdBusyW;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] val;

        assign addr = bus.rd_addr[i*AW +: AW];

        always_comb begin
            val = regs[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr0Live && bus.wr0_addr == addr) val = bus.wr0_data;
            if (wr1Live && bus.wr1_addr == addr) val = bus.wr1_data;
`endif
            if (!ready || addr == '0) val = '0;
        end

        assign rdDataW[i*XLEN +: XLEN] = val;
        assign rdBusyW[i]              = ready & busy[addr];
    end

    assign bus.rd_data = rdDataW;
    assign bus.rd_busy = rdBusyW;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic checked against an array-based model.
// A second instance (AW=4, NRD=4) covers the reduced-depth, four-read-port build.
`timescale 1ns/1ps
module tb_regfile_mp;
    localparam int XLEN   = 32;
    localparam int AW     = 5;
    localparam int NRD    = 2;
    localparam int DEPTH  = 1 << AW;
    localparam int RAW    = NRD * AW;
    localparam int AW2    = 4;
    localparam int NRD2   = 4;
    localparam int DEPTH2 = 1 << AW2;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus ();
    regfile_mp #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) dut (.clk(clk), .rst(rst), .bus(bus));

    regfile_mp_if #(.XLEN(XLEN), .AW(AW2), .NRD(NRD2)) bus2 ();
    regfile_mp #(.XLEN(XLEN), .AW(AW2), .NRD(NRD2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: architectural register array, busy set, and sweep progress.
    logic [XLEN-1:0] mem [DEPTH];
    bit [DEPTH-1:0]  busyM;
    bit              readyM;
    int              sweepM;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] refRead(input logic [AW-1:0] a);
        if (!readyM || a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (bus.wr1_en && bus.wr1_addr == a) return bus.wr1_data;
        if (bus.wr0_en && bus.wr0_addr == a) return bus.wr0_data;
`endif
        return mem[a];
    endfunction

    task automatic modelUpdate();
        if (rst) begin
            readyM = 1'b0;
            sweepM = 0;
            busyM  = '0;
        end else if (!readyM) begin
            mem[sweepM] = '0;
            sweepM++;
            if (sweepM == DEPTH) readyM = 1'b1;
        end else begin
            if (bus.wr0_en && bus.wr0_addr != '0) begin
                mem[bus.wr0_addr]   = bus.wr0_data;
                busyM[bus.wr0_addr] = 1'b0;
            end
            if (bus.wr1_en && bus.wr1_addr != '0) begin
                mem[bus.wr1_addr]   = bus.wr1_data;
                busyM[bus.wr1_addr] = 1'b0;
            end
            if (bus.sb_set_en && bus.sb_set_addr != '0) busyM[bus.sb_set_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic idle();
        bus.wr0_en = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_en = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
        bus.sb_set_en = 1'b0; bus.sb_set_addr = '0;
    endtask

    task automatic setRd(input int i, input logic [AW-1:0] a);
        bus.rd_addr[i*AW +: AW] = a;
    endtask

    task automatic checkOutputs(input string tag);
        logic [AW-1:0] a;
        #1;
        for (int i = 0; i < NRD; i++) begin
            a = bus.rd_addr[i*AW +: AW];
            chk($sformatf("%s rd_data[%0d]", tag, i), 64'(bus.rd_data[i*XLEN +: XLEN]), 64'(refRead(a)));
            chk($sformatf("%s rd_busy[%0d]", tag, i), 64'(bus.rd_busy[i]), 64'(readyM ? busyM[a] : 1'b0));
        end
        chk($sformatf("%s init_done", tag), 64'(bus.init_done), 64'(readyM));
    endtask

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        idle();
        bus.rd_addr = '0;
        bus2.wr0_en = 1'b0; bus2.wr0_addr = '0; bus2.wr0_data = '0;
        bus2.wr1_en = 1'b0; bus2.wr1_addr = '0; bus2.wr1_data = '0;
        bus2.sb_set_en = 1'b0; bus2.sb_set_addr = '0; bus2.rd_addr = '0;
        readyM = 1'b0; sweepM = 0; busyM = '0;

        // Reset held three cycles.
        repeat (3) tick();
        bus.rd_addr = RAW'($urandom);
        checkOutputs("reset");

        // Init sweep: 32 cycles of init_done low, writes ignored, reads zero.
        rst = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            bus.rd_addr = RAW'($urandom);
            if (c == 10) begin
                bus.wr0_en = 1'b1; bus.wr0_addr = AW'(5); bus.wr0_data = 32'h0000_1234;
                bus.sb_set_en = 1'b1; bus.sb_set_addr = AW'(5);
            end
            checkOutputs("sweep");
            chk("sweep init_done low", 64'(bus.init_done), 64'(0));
            tick();
            idle();
        end
        chk("sweep init_done high", 64'(bus.init_done), 64'(1));
        setRd(0, AW'(5)); setRd(1, AW'(5));
        #1;
        chk("sweep x5 ignored", 64'(bus.rd_data[0 +: XLEN]), 64'(0));
        chk("sweep x5 not busy", 64'(bus.rd_busy[0]), 64'(0));

        // Basic read/write and x0 hardwiring.
        bus.wr0_en = 1'b1; bus.wr0_addr = AW'(3); bus.wr0_data = 32'hDEAD_BEEF;
        tick(); idle();
        setRd(0, AW'(3)); setRd(1, AW'(0));
        #1;
        chk("basic x3", 64'(bus.rd_data[0 +: XLEN]), 64'(32'hDEAD_BEEF));
        chk("basic x0", 64'(bus.rd_data[XLEN +: XLEN]), 64'(0));
        bus.wr0_en = 1'b1; bus.wr0_addr = AW'(0); bus.wr0_data = 32'hFFFF_FFFF;
        tick(); idle();
        setRd(0, AW'(0));
        checkOutputs("x0 write");
        chk("x0 stays zero", 64'(bus.rd_data[0 +: XLEN]), 64'(0));

        // Dual-write conflict on x7: port 1 wins.
        bus.wr0_en = 1'b1; bus.wr0_addr = AW'(7); bus.wr0_data = 32'h1111_1111;
        bus.wr1_en = 1'b1; bus.wr1_addr = AW'(7); bus.wr1_data = 32'h2222_2222;
        setRd(0, AW'(7));
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("conflict same-cycle", 64'(bus.rd_data[0 +: XLEN]), 64'(32'h2222_2222));
`else
        chk("conflict same-cycle", 64'(bus.rd_data[0 +: XLEN]), 64'(0));
`endif
        tick(); idle();
        #1;
        chk("conflict x7", 64'(bus.rd_data[0 +: XLEN]), 64'(32'h2222_2222));

        // Scoreboard set, set-beats-clear, clear, and x0.
        bus.sb_set_en = 1'b1; bus.sb_set_addr = AW'(9);
        setRd(1, AW'(9));
        #1;
        chk("sb no same-cycle bypass", 64'(bus.rd_busy[1]), 64'(0));
        tick(); idle();
        #1;
        chk("sb x9 set", 64'(bus.rd_busy[1]), 64'(1));
        bus.sb_set_en = 1'b1; bus.sb_set_addr = AW'(9);
        bus.wr1_en = 1'b1; bus.wr1_addr = AW'(9); bus.wr1_data = 32'h0BAD_F00D;
        tick(); idle();
        #1;
        chk("sb set beats clear", 64'(bus.rd_busy[1]), 64'(1));
        bus.wr0_en = 1'b1; bus.wr0_addr = AW'(9); bus.wr0_data = 32'h600D_CAFE;
        #1;
        chk("sb clear not yet", 64'(bus.rd_busy[1]), 64'(1));
        tick(); idle();
        #1;
        chk("sb x9 cleared", 64'(bus.rd_busy[1]), 64'(0));
        bus.sb_set_en = 1'b1; bus.sb_set_addr = AW'(0);
        setRd(1, AW'(0));
        tick(); idle();
        checkOutputs("sb x0");
        chk("sb x0 never busy", 64'(bus.rd_busy[1]), 64'(0));

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.wr0_en = ($urandom_range(0, 2) != 0);
            bus.wr0_addr = AW'($urandom); bus.wr0_data = XLEN'($urandom);
            bus.wr1_en = ($urandom_range(0, 2) == 0);
            bus.wr1_addr = ($urandom_range(0, 3) == 0) ? bus.wr0_addr : AW'($urandom);
            bus.wr1_data = XLEN'($urandom);
            bus.sb_set_en = ($urandom_range(0, 1) == 0);
            bus.sb_set_addr = ($urandom_range(0, 3) == 0) ? bus.wr1_addr : AW'($urandom);
            bus.rd_addr = RAW'($urandom);
            if ($urandom_range(0, 2) == 0) setRd(0, bus.wr0_addr);
            if ($urandom_range(0, 2) == 0) setRd(1, bus.wr1_addr);
            checkOutputs("random");
            tick();
        end
        rst = 1'b0;
        idle();
        for (int c = 0; c < DEPTH + 2; c++) tick();

        // Reset mid-operation: x4 written and busy, then a one-cycle reset.
        bus.wr0_en = 1'b1; bus.wr0_addr = AW'(4); bus.wr0_data = 32'hA5A5_A5A5;
        bus.sb_set_en = 1'b1; bus.sb_set_addr = AW'(4);
        tick(); idle();
        setRd(0, AW'(4)); setRd(1, AW'(4));
        #1;
        chk("midrst x4 data", 64'(bus.rd_data[0 +: XLEN]), 64'(32'hA5A5_A5A5));
        chk("midrst x4 busy", 64'(bus.rd_busy[0]), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst busy cleared", 64'(bus.rd_busy[0]), 64'(0));
        chk("midrst init_done low", 64'(bus.init_done), 64'(0));
        for (int c = 0; c < DEPTH; c++) begin
            chk("midrst sweep low", 64'(bus.init_done), 64'(0));
            tick();
        end
        checkOutputs("midrst done");
        chk("midrst init_done high", 64'(bus.init_done), 64'(1));
        chk("midrst x4 zeroed", 64'(bus.rd_data[0 +: XLEN]), 64'(0));
        chk("midrst x4 idle", 64'(bus.rd_busy[0]), 64'(0));

        // Reduced build: 16-cycle sweep and four simultaneous reads.
        rst2 = 1'b0;
        for (int c = 0; c < DEPTH2; c++) begin
            chk("nrd4 sweep low", 64'(bus2.init_done), 64'(0));
            tick();
        end
        chk("nrd4 sweep high", 64'(bus2.init_done), 64'(1));
        bus2.wr0_en = 1'b1; bus2.wr0_addr = AW2'(1);  bus2.wr0_data = 32'h0101_0101;
        bus2.wr1_en = 1'b1; bus2.wr1_addr = AW2'(2);  bus2.wr1_data = 32'h0202_0202;
        tick();
        bus2.wr0_addr = AW2'(15); bus2.wr0_data = 32'h0F0F_0F0F;
        bus2.wr1_en = 1'b0;
        tick();
        bus2.wr0_en = 1'b0;
        bus2.rd_addr = {AW2'(0), AW2'(15), AW2'(2), AW2'(1)};
        #1;
        chk("nrd4 x1",  64'(bus2.rd_data[0*XLEN +: XLEN]), 64'(32'h0101_0101));
        chk("nrd4 x2",  64'(bus2.rd_data[1*XLEN +: XLEN]), 64'(32'h0202_0202));
        chk("nrd4 x15", 64'(bus2.rd_data[2*XLEN +: XLEN]), 64'(32'h0F0F_0F0F));
        chk("nrd4 x0",  64'(bus2.rd_data[3*XLEN +: XLEN]), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
